// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS control register bank: register selects,
// CTRL bit positions, AXI response codes and the byte-strobe merge helper.
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_CTRL      = 2'd0,
    REG_PHASE_INC = 2'd1,
    REG_PHASE_OFF = 2'd2,
    REG_STATUS    = 2'd3
  } reg_sel_e;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_PHASE_CLR = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_wr_join.sv
// AXI4-Lite write-channel join: independent AW/W holding registers, a commit
// strobe when both are full and no B is outstanding, and the B handshake.
module axil_wr_join #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   commit_addr,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH/8-1:0] commit_strb
);

  logic aw_full, w_full;
  logic aw_full_next, w_full_next;

  // A new pair may sit in the holders while B is pending; it commits only after B drains.
  assign commit = aw_full & w_full & ~bvalid;

  always_comb begin
    aw_full_next = aw_full;
    w_full_next  = w_full;
    if (commit) begin
      aw_full_next = 1'b0;
      w_full_next  = 1'b0;
    end else begin
      if (awvalid && awready) aw_full_next = 1'b1;
      if (wvalid && wready)   w_full_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      awready     <= 1'b0;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      commit_addr <= '0;
      commit_data <= '0;
      commit_strb <= '0;
    end else begin
      aw_full <= aw_full_next;
      w_full  <= w_full_next;
      awready <= ~aw_full_next;
      wready  <= ~w_full_next;
      if (awvalid && awready) commit_addr <= awaddr;
      if (wvalid && wready) begin
        commit_data <= wdata;
        commit_strb <= wstrb;
      end
      if (commit)      bvalid <= 1'b1;
      else if (bready) bvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/dds_ctrl_axil_slave.sv
// AXI4-Lite register bank for the DDS: CTRL, PHASE_INC, PHASE_OFF, STATUS.
// Writes go through axil_wr_join; reads are a registered mux with 1-cycle latency.
module dds_ctrl_axil_slave
  import dds_ctrl_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] RST_PHASE_INC      = 32'h0000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     dds_phase_inc,
  output logic [31:0]                     dds_phase_off,
  output logic                            dds_enable,
  output logic                            dds_cfg_update,
  input  logic [31:0]                     dds_status
);

  logic                            commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   commit_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   commit_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] commit_strb;
  reg_sel_e                        wr_sel, rd_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_mux;
  logic                            unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], commit_addr[1:0]};

  axil_wr_join #(
    .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
  ) u_wr_join (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .bvalid      (S_AXI_BVALID),
    .bready      (S_AXI_BREADY),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;
  assign wr_sel      = reg_sel_e'(commit_addr[3:2]);
  assign rd_sel      = reg_sel_e'(S_AXI_ARADDR[3:2]);

  // phase_clear has no storage: it only produces the commit pulse and reads back 0.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dds_enable     <= 1'b0;
      dds_phase_inc  <= RST_PHASE_INC;
      dds_phase_off  <= '0;
      dds_cfg_update <= 1'b0;
    end else begin
      dds_cfg_update <= 1'b0;
      if (commit) begin
        case (wr_sel)
          REG_CTRL: begin
            if (commit_strb[0]) dds_enable <= commit_data[CTRL_ENABLE];
            dds_cfg_update <= commit_strb[0] & commit_data[CTRL_PHASE_CLR];
          end
          REG_PHASE_INC: begin
            dds_phase_inc  <= apply_strb(dds_phase_inc, commit_data, commit_strb);
            dds_cfg_update <= 1'b1;
          end
          REG_PHASE_OFF: begin
            dds_phase_off  <= apply_strb(dds_phase_off, commit_data, commit_strb);
            dds_cfg_update <= 1'b1;
          end
          REG_STATUS: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_CTRL:      rd_mux[CTRL_ENABLE] = dds_enable;
      REG_PHASE_INC: rd_mux = dds_phase_inc;
      REG_PHASE_OFF: rd_mux = dds_phase_off;
      REG_STATUS:    rd_mux = dds_status;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RDATA   <= rd_mux;
        S_AXI_RVALID  <= 1'b1;
        S_AXI_ARREADY <= 1'b0;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID  <= 1'b0;
        S_AXI_ARREADY <= 1'b1;
      end else begin
        S_AXI_ARREADY <= ~S_AXI_RVALID;
      end
    end
  end

endmodule

// File: tb/tb_dds_ctrl_axil_slave.sv
// Self-checking bench for dds_ctrl_axil_slave: scenario tasks against a
// register-map model of CTRL/PHASE_INC/PHASE_OFF/STATUS and cfg_update pulses.
module tb_dds_ctrl_axil_slave;

  localparam logic [31:0] RST_INC = 32'h1234_5678;

  logic        ACLK, ARESETN;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] dds_phase_inc, dds_phase_off, dds_status;
  logic        dds_enable, dds_cfg_update;

  dds_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .RST_PHASE_INC      (RST_INC)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .S_AXI_AWADDR   (awaddr),
    .S_AXI_AWPROT   (awprot),
    .S_AXI_AWVALID  (awvalid),
    .S_AXI_AWREADY  (awready),
    .S_AXI_WDATA    (wdata),
    .S_AXI_WSTRB    (wstrb),
    .S_AXI_WVALID   (wvalid),
    .S_AXI_WREADY   (wready),
    .S_AXI_BRESP    (bresp),
    .S_AXI_BVALID   (bvalid),
    .S_AXI_BREADY   (bready),
    .S_AXI_ARADDR   (araddr),
    .S_AXI_ARPROT   (arprot),
    .S_AXI_ARVALID  (arvalid),
    .S_AXI_ARREADY  (arready),
    .S_AXI_RDATA    (rdata),
    .S_AXI_RRESP    (rresp),
    .S_AXI_RVALID   (rvalid),
    .S_AXI_RREADY   (rready),
    .dds_phase_inc  (dds_phase_inc),
    .dds_phase_off  (dds_phase_off),
    .dds_enable     (dds_enable),
    .dds_cfg_update (dds_cfg_update),
    .dds_status     (dds_status)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int wide_cnt  = 0;
  logic prev_cfg = 1'b0;

  always @(negedge ACLK) begin
    if (dds_cfg_update === 1'b1) begin
      pulse_cnt++;
      if (prev_cfg === 1'b1) wide_cnt++;
    end
    prev_cfg = dds_cfg_update;
  end

  // Register-map model
  logic        m_en;
  logic [31:0] m_inc, m_off;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic int model_write(input logic [3:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb);
    case (addr[3:2])
      2'd0: begin
        if (strb[0]) m_en = data[0];
        return (strb[0] && data[1]) ? 1 : 0;
      end
      2'd1: begin m_inc = merge(m_inc, data, strb); return 1; end
      2'd2: begin m_off = merge(m_off, data, strb); return 1; end
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr[3:2])
      2'd0:    return {31'd0, m_en};
      2'd1:    return m_inc;
      2'd2:    return m_off;
      default: return dds_status;
    endcase
  endfunction

  function automatic void model_reset();
    m_en  = 1'b0;
    m_inc = RST_INC;
    m_off = 32'd0;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw_w(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    int cyc = 0;
    int aw_done = 0;
    int w_done = 0;
    logic hs_aw, hs_w;
    while (!(aw_done != 0 && w_done != 0)) begin
      if (aw_done == 0 && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (w_done == 0 && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid = 1'b0; w_done = 1; end
      cyc++;
      if (cyc > 100) begin
        n_checks++; n_fail++;
        $display("FAIL write_handshake_timeout: aw_done=%0d w_done=%0d after %0d cycles", aw_done, w_done, cyc);
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_b();
    int cyc = 0;
    while (bvalid !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bvalid_timeout: bvalid=%b required 1 within 50 cycles", bvalid);
    end else begin
      if (bresp !== 2'b00) begin n_fail++; $display("FAIL bresp: got %b required 00", bresp); end
      tick();
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    send_aw_w(addr, data, strb, aw_dly, w_dly);
    wait_b();
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int cyc = 0;
    data = 32'hxxxx_xxxx;
    arvalid = 1'b1; araddr = addr;
    while (arready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    if (arready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL arready_timeout: arready=%b required 1", arready);
      arvalid = 1'b0;
      return;
    end
    tick();
    arvalid = 1'b0;
    cyc = 0;
    while (rvalid !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    n_checks++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid_timeout: rvalid=%b required 1", rvalid);
    end else begin
      if (rresp !== 2'b00) begin n_fail++; $display("FAIL rresp: got %b required 00", rresp); end
      data = rdata;
      tick();
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
    araddr = '0; arprot = '0; arvalid = 0; rready = 1; dds_status = 32'hC0DE_0001;
    model_reset();
    repeat (3) tick();
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    n_checks++;
    if (dds_phase_inc !== RST_INC) begin n_fail++; $display("FAIL reset_phase_inc: got %h required %h", dds_phase_inc, RST_INC); end
    n_checks++;
    if ({dds_phase_off, dds_enable, dds_cfg_update} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs: off=%h en=%b upd=%b required all 0", dds_phase_off, dds_enable, dds_cfg_update);
    end
    ARESETN = 1'b1;
    #1;
    n_checks++;
    if ({awready, wready} !== 2'b00) begin n_fail++; $display("FAIL ready_before_edge: got %b required 00", {awready, wready}); end
    tick();
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_edge: got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_sequential();
    int p0, exp_p;
    logic [31:0] rd;
    p0 = pulse_cnt; exp_p = 0;
    dds_status = $urandom;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
      exp_p += model_write(4'(i * 4), 32'(i + 1), 4'hF);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      n_checks++;
      if (rd !== model_read(4'(i * 4))) begin
        n_fail++; $display("FAIL seq_read[%0d]: got %h required %h", i, rd, model_read(4'(i * 4)));
      end
    end
    n_checks++;
    if ({dds_enable, dds_phase_inc, dds_phase_off} !== {m_en, m_inc, m_off}) begin
      n_fail++; $display("FAIL seq_outputs: en=%b inc=%h off=%h required %b %h %h", dds_enable, dds_phase_inc, dds_phase_off, m_en, m_inc, m_off);
    end
    n_checks++;
    if (pulse_cnt - p0 !== exp_p) begin n_fail++; $display("FAIL seq_pulses: got %0d required %0d", pulse_cnt - p0, exp_p); end
  endtask

  task automatic test_w_first();
    void'(model_write(4'h4, 32'hDEAD_BEEF, 4'hF));
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    n_checks++;
    if (wready !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready: got %b required 0", wready); end
    repeat (4) tick();
    n_checks++;
    if ({bvalid, wready} !== 2'b00) begin n_fail++; $display("FAIL wfirst_idle: bvalid,wready=%b required 00", {bvalid, wready}); end
    awvalid = 1'b1; awaddr = 4'h4;
    tick();
    awvalid = 1'b0;
    tick();
    n_checks++;
    if ({bvalid, dds_cfg_update, dds_phase_inc} !== {2'b11, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL wfirst_commit: bvalid=%b upd=%b inc=%h required 1 1 deadbeef", bvalid, dds_cfg_update, dds_phase_inc);
    end
    tick();
  endtask

  task automatic test_strobe();
    int p0;
    axi_write(4'h8, 32'd0, 4'hF, 0, 0);
    void'(model_write(4'h8, 32'd0, 4'hF));
    p0 = pulse_cnt;
    axi_write(4'h8, 32'hAABB_CCDD, 4'b0010, 1, 0);
    void'(model_write(4'h8, 32'hAABB_CCDD, 4'b0010));
    n_checks++;
    if (dds_phase_off !== 32'h0000_CC00) begin n_fail++; $display("FAIL strobe_off: got %h required 0000cc00", dds_phase_off); end
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL strobe_pulses: got %0d required 1", pulse_cnt - p0); end
  endtask

  task automatic test_random();
    logic [3:0]  a, ra, s;
    logic [31:0] d, rd;
    int p0, exp_p;
    for (int it = 0; it < 24; it++) begin
      a = 4'($urandom_range(0, 15)); d = $urandom; s = 4'($urandom_range(0, 15));
      if (it % 4 == 0) d[1] = 1'b1;
      dds_status = $urandom;
      p0 = pulse_cnt;
      axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
      exp_p = model_write(a, d, s);
      n_checks++;
      if (pulse_cnt - p0 !== exp_p) begin n_fail++; $display("FAIL rand_pulse[%0d]: addr=%h strb=%b got %0d required %0d", it, a, s, pulse_cnt - p0, exp_p); end
      n_checks++;
      if ({dds_enable, dds_phase_inc, dds_phase_off} !== {m_en, m_inc, m_off}) begin
        n_fail++; $display("FAIL rand_outputs[%0d]: en=%b inc=%h off=%h required %b %h %h", it, dds_enable, dds_phase_inc, dds_phase_off, m_en, m_inc, m_off);
      end
      ra = 4'($urandom_range(0, 15));
      axi_read(ra, rd);
      n_checks++;
      if (rd !== model_read(ra)) begin n_fail++; $display("FAIL rand_read[%0d]: addr=%h got %h required %h", it, ra, rd, model_read(ra)); end
    end
  endtask

  task automatic test_b_hold();
    logic [31:0] va, vb;
    int cyc, nb;
    va = $urandom; vb = ~va;
    bready = 1'b0;
    send_aw_w(4'h4, va, 4'hF, 0, 0);
    cyc = 0;
    while (bvalid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    send_aw_w(4'h4, vb, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({awready, wready, bvalid, dds_phase_inc} !== {3'b001, va}) begin
        n_fail++; $display("FAIL bhold[%0d]: awready=%b wready=%b bvalid=%b inc=%h required 0 0 1 %h", i, awready, wready, bvalid, dds_phase_inc, va);
      end
      tick();
    end
    bready = 1'b1;
    tick();
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (bvalid === 1'b1) nb++;
      tick();
    end
    void'(model_write(4'h4, va, 4'hF));
    void'(model_write(4'h4, vb, 4'hF));
    n_checks++;
    if (nb !== 1) begin n_fail++; $display("FAIL bhold_second_b: got %0d responses required 1", nb); end
    n_checks++;
    if (dds_phase_inc !== m_inc) begin n_fail++; $display("FAIL bhold_inc: got %h required %h", dds_phase_inc, m_inc); end
  endtask

  task automatic test_r_hold();
    logic [31:0] held;
    rready = 1'b0;
    arvalid = 1'b1; araddr = 4'h4;
    tick();
    araddr = 4'h8;
    held = rdata;
    n_checks++;
    if ({rvalid, rdata} !== {1'b1, m_inc}) begin n_fail++; $display("FAIL rhold_first: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, m_inc); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({rvalid, arready, rdata} !== {2'b10, held}) begin
        n_fail++; $display("FAIL rhold[%0d]: rvalid=%b arready=%b rdata=%h required 1 0 %h", i, rvalid, arready, rdata, held);
      end
    end
    rready = 1'b1;
    tick();
    n_checks++;
    if ({arready, rvalid} !== 2'b10) begin n_fail++; $display("FAIL rhold_release: arready,rvalid=%b required 10", {arready, rvalid}); end
    tick();
    arvalid = 1'b0;
    n_checks++;
    if ({rvalid, rdata} !== {1'b1, m_off}) begin n_fail++; $display("FAIL rhold_next_ar: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, m_off); end
    tick();
  endtask

  task automatic test_same_cycle();
    logic [31:0] old_v, new_v;
    old_v = m_off; new_v = ~m_off;
    awvalid = 1'b1; awaddr = 4'h8; wvalid = 1'b1; wdata = new_v; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 4'h8;
    tick();
    arvalid = 1'b0;
    void'(model_write(4'h8, new_v, 4'hF));
    n_checks++;
    if ({rvalid, rdata} !== {1'b1, old_v}) begin n_fail++; $display("FAIL same_cycle_read: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, old_v); end
    n_checks++;
    if ({bvalid, dds_phase_off} !== {1'b1, new_v}) begin n_fail++; $display("FAIL same_cycle_write: bvalid=%b off=%h required 1 %h", bvalid, dds_phase_off, new_v); end
    tick();
    n_checks++;
    if ({bvalid, rvalid} !== 2'b00) begin n_fail++; $display("FAIL same_cycle_done: bvalid,rvalid=%b required 00", {bvalid, rvalid}); end
  endtask

  task automatic test_reset_mid();
    int p0, cyc, nb;
    logic [31:0] rd;
    rready = 1'b0; bready = 1'b0;
    arvalid = 1'b1; araddr = 4'h0;
    tick();
    arvalid = 1'b0;
    send_aw_w(4'h4, 32'h0BAD_F00D, 4'hF, 0, 0);
    cyc = 0;
    while (bvalid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    send_aw_w(4'h8, 32'h5555_AAAA, 4'hF, 0, 0);
    tick();
    p0 = pulse_cnt;
    ARESETN = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_handshake: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_checks++;
    if ({dds_enable, dds_phase_inc, dds_phase_off} !== {m_en, m_inc, m_off}) begin
      n_fail++; $display("FAIL midreset_regs: en=%b inc=%h off=%h required %b %h %h", dds_enable, dds_phase_inc, dds_phase_off, m_en, m_inc, m_off);
    end
    repeat (2) tick();
    ARESETN = 1'b1; bready = 1'b1; rready = 1'b1;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bvalid === 1'b1) nb++;
    end
    n_checks++;
    if ({nb, pulse_cnt - p0} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL midreset_no_commit: b=%0d pulses=%0d required 0 0", nb, pulse_cnt - p0); end
    axi_read(4'h8, rd);
    n_checks++;
    if (rd !== m_off) begin n_fail++; $display("FAIL midreset_readback: got %h required %h", rd, m_off); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_w_first();
    test_strobe();
    test_random();
    test_b_hold();
    test_r_hold();
    test_same_cycle();
    test_reset_mid();
    n_checks++;
    if (wide_cnt !== 0) begin n_fail++; $display("FAIL cfg_update_width: %0d multi-cycle pulses required 0", wide_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
